lsu_mem_stage: RTL and testbench

- Load/store unit directly downstream of the ALU.
- Consumes the ALU result as the effective byte address and the second register operand (RD2) as store data.
- Runs one data-memory transaction over a req/gnt/rvalid bus and returns the aligned, sign- or zero-extended load value for writeback.
- Handles one access at a time and stalls the upstream stage through req_ready.

---
 rtl/lsu_pkg.sv | 12 +
 rtl/lsu_mem_stage_align.sv | 30 +++
 rtl/lsu_mem_stage.sv | 106 ++++++++++
 tb/tb_lsu_mem_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state type and alignment check for the LSU.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3 == F3_H || f3 == F3_HU) && off[0]) || (f3 == F3_W && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_mem_stage_align.sv
// lsu_align: byte enables, store lane replication and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  logic [31:0] s;
  assign s = rdata >> {offset, 3'b000};
  always_comb begin
    be        = funct3[1:0] == 2'b00 ? 4'b0001 << offset :
                funct3[1:0] == 2'b01 ? 4'b0011 << offset : 4'b1111;
    wdata_rep = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    rdata_ext = '0;
    case (funct3)
      F3_B:    rdata_ext = {{24{s[7]}}, s[7:0]};
      F3_H:    rdata_ext = {{16{s[15]}}, s[15:0]};
      F3_W:    rdata_ext = s;
      F3_BU:   rdata_ext = {24'h0, s[7:0]};
      F3_HU:   rdata_ext = {16'h0, s[15:0]};
      default: rdata_ext = '0;
    endcase
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: single-outstanding load/store unit over a req/gnt/rvalid data bus.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        rd_idx,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  lsu_state_t state_q, state_d;
  logic is_store_q, is_store_d, err_q, err_d, fault;
  logic [2:0] f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, data_q, data_d, wrep, ext;
  logic [4:0] rd_q, rd_d;
  logic [3:0] be;
  lsu_align u_align (
    .funct3   (f3_q),
    .offset   (addr_q[1:0]),
    .wdata    (wdata_q),
    .rdata    (mem_rdata),
    .be       (be),
    .wdata_rep(wrep),
    .rdata_ext(ext)
  );
  always_comb begin
    fault = funct3 inside {3'b011, 3'b110, 3'b111} || (is_store && funct3[2]) ||
            is_misaligned(funct3, addr[1:0]);
    state_d    = state_q;
    is_store_d = is_store_q;
    err_d      = err_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    rd_d       = rd_q;
    case (state_q)
      IDLE: if (req_valid) begin
        is_store_d = is_store;
        f3_d       = funct3;
        addr_d     = addr;
        wdata_d    = wdata;
        rd_d       = rd_idx;
        err_d      = fault;
        data_d     = '0;
        state_d    = fault ? RESP : REQ;
      end
      REQ:  if (mem_gnt) state_d = is_store_q ? RESP : WAIT;
      WAIT: if (mem_rvalid) begin
        data_d  = ext;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      err_q      <= err_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
    end
  assign req_ready  = state_q == IDLE;
  assign mem_req    = state_q == REQ;
  assign mem_we     = mem_req && is_store_q;
  assign mem_addr   = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be     = mem_req ? be : 4'b0000;
  assign mem_wdata  = mem_we ? wrep : '0;
  assign resp_valid = state_q == RESP;
  assign resp_data  = resp_valid ? data_q : '0;
  assign resp_rd    = resp_valid ? rd_q : 5'd0;
  assign resp_err   = resp_valid && err_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed self-checking bench for lsu_mem_stage.
module tb_lsu_mem_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 0, is_store = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic [4:0] rd_idx = 0;
  logic req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0] resp_data, mem_addr, mem_wdata;
  logic [4:0] resp_rd;
  logic [3:0] mem_be;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  lsu_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata), .rd_idx(rd_idx),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] w, input logic [4:0] rd);
    req_valid = 1; is_store = st; funct3 = f3; addr = a; wdata = w; rd_idx = rd;
    chk("ready_at_accept", req_ready, 1);
    tick;
    req_valid = 0;
  endtask
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    accept(0, f3, a, 32'h5555_5555, rd);
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_addr"}, mem_addr, a & ~32'h3);
    chk({tag, "_be"}, mem_be, exp_be);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_wd"}, mem_wdata, 0);
    mem_gnt = 1;
    mem_rvalid = 1; mem_rdata = 32'h1111_1111;
    tick;
    mem_gnt = 0;
    chk({tag, "_wait_req"}, mem_req, 0);
    chk({tag, "_wait_rv"}, resp_valid, 0);
    mem_rvalid = 1; mem_rdata = rdata;
    tick;
    mem_rvalid = 0;
    chk({tag, "_rv"}, resp_valid, 1);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_rd"}, resp_rd, rd);
    chk({tag, "_err"}, resp_err, 0);
    chk({tag, "_busy"}, req_ready, 0);
    tick;
    chk({tag, "_rv_end"}, resp_valid, 0);
  endtask
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] w, input logic [4:0] rd, input int dly,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    accept(1, f3, a, w, rd);
    for (int i = 0; i <= dly; i++) begin
      chk({tag, "_req"}, mem_req, 1);
      chk({tag, "_addr"}, mem_addr, a & ~32'h3);
      chk({tag, "_be"}, mem_be, exp_be);
      chk({tag, "_wd"}, mem_wdata, exp_wd);
      chk({tag, "_we"}, mem_we, 1);
      chk({tag, "_norv"}, resp_valid, 0);
      mem_gnt = i == dly;
      tick;
    end
    mem_gnt = 0;
    chk({tag, "_rv"}, resp_valid, 1);
    chk({tag, "_data"}, resp_data, 0);
    chk({tag, "_rd"}, resp_rd, rd);
    chk({tag, "_err"}, resp_err, 0);
    chk({tag, "_idle_req"}, mem_req, 0);
    tick;
    chk({tag, "_rv_end"}, resp_valid, 0);
  endtask
  task automatic do_fault(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [4:0] rd);
    accept(st, f3, a, 32'hFFFF_FFFF, rd);
    chk({tag, "_noreq"}, mem_req, 0);
    chk({tag, "_rv"}, resp_valid, 1);
    chk({tag, "_err"}, resp_err, 1);
    chk({tag, "_data"}, resp_data, 0);
    chk({tag, "_rd"}, resp_rd, rd);
    tick;
    chk({tag, "_rv_end"}, resp_valid, 0);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_noreq2"}, mem_req, 0);
  endtask
  initial begin
    tick; tick;
    chk("rst_ready", req_ready, 1);
    chk("rst_rv", resp_valid, 0);
    chk("rst_req", mem_req, 0);
    rst_n = 1;
    tick;
    do_load("lw", 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd3, 4'b1111, 32'hDEAD_BEEF);
    do_load("lb", 3'b000, 32'h203, 32'h80AA_BBCC, 5'd4, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h203, 32'h80AA_BBCC, 5'd5, 4'b1000, 32'h0000_0080);
    do_load("lh", 3'b001, 32'h202, 32'h8001_1234, 5'd6, 4'b1100, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h202, 32'h8001_1234, 5'd7, 4'b1100, 32'h0000_8001);
    do_load("lb1", 3'b000, 32'h201, 32'h0000_7F00, 5'd8, 4'b0010, 32'h0000_007F);
    do_store("sh", 3'b001, 32'h302, 32'h1234_ABCD, 5'd9, 3, 4'b1100, 32'hABCD_ABCD);
    do_store("sb", 3'b000, 32'h401, 32'h0000_0077, 5'd10, 0, 4'b0010, 32'h7777_7777);
    do_store("sw", 3'b010, 32'h404, 32'hCAFE_F00D, 5'd11, 1, 4'b1111, 32'hCAFE_F00D);
    do_fault("lw_mis", 0, 3'b010, 32'h101, 5'd12);
    do_fault("f3_011", 0, 3'b011, 32'h100, 5'd13);
    do_fault("lh_mis", 0, 3'b001, 32'h103, 5'd14);
    do_fault("sbu", 1, 3'b100, 32'h100, 5'd15);
    accept(0, 3'b010, 32'h500, 0, 5'd16);
    mem_gnt = 1;
    tick;
    mem_gnt = 0;
    chk("rstw_inwait", mem_req, 0);
    #2 rst_n = 0;
    #1;
    chk("rstw_ready", req_ready, 1);
    chk("rstw_rv", resp_valid, 0);
    chk("rstw_data", resp_data, 0);
    chk("rstw_rd", resp_rd, 0);
    chk("rstw_req", mem_req, 0);
    tick;
    rst_n = 1;
    tick;
    mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    tick;
    mem_rvalid = 0;
    chk("rstw_stray_rv", resp_valid, 0);
    chk("rstw_stray_ready", req_ready, 1);
    tick;
    chk("rstw_stray_rv2", resp_valid, 0);
    req_valid = 1; is_store = 1; funct3 = 3'b010; addr = 32'h600; wdata = 32'hA; rd_idx = 5'd20;
    chk("b2b_ready0", req_ready, 1);
    tick;
    addr = 32'h604; wdata = 32'hB; rd_idx = 5'd21;
    chk("b2b_busy1", req_ready, 0);
    chk("b2b_addr_a", mem_addr, 32'h600);
    mem_gnt = 1;
    tick;
    mem_gnt = 0;
    chk("b2b_rv_a", resp_valid, 1);
    chk("b2b_rd_a", resp_rd, 20);
    chk("b2b_busy2", req_ready, 0);
    tick;
    chk("b2b_ready3", req_ready, 1);
    chk("b2b_norv3", resp_valid, 0);
    tick;
    req_valid = 0;
    chk("b2b_req_b", mem_req, 1);
    chk("b2b_addr_b", mem_addr, 32'h604);
    chk("b2b_wd_b", mem_wdata, 32'hB);
    mem_gnt = 1;
    tick;
    mem_gnt = 0;
    chk("b2b_rv_b", resp_valid, 1);
    chk("b2b_rd_b", resp_rd, 21);
    tick;
    chk("b2b_idle", req_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
